// File: rtl/alu_regfile_16bit.sv
// ---------------------------------------------------------------------------
// alu_regfile_16bit
//
// Eight-entry, 16-bit register file plus a 4-bit status register that feeds
// the 16-bit ALU.  It supplies the ALU operands A, B and Cin, and captures the
// ALU Result and the C/V/Z/N flags on the next rising clock edge.  Together
// with the ALU it forms a single-cycle read/compute/write-back loop.
//
// Ports:
//   clk      in   1   system clock, all state changes on the rising edge
//   rst      in   1   asynchronous, active-high reset (clears all state)
//   ra_addr  in   3   register index driven onto A
//   rb_addr  in   3   register index driven onto B
//   A        out 16   reg[ra_addr], combinational read
//   B        out 16   reg[rb_addr], combinational read
//   Cin      out  1   stored carry flag (stat[3])
//   wr_en    in   1   write wr_data into reg[wr_addr] at the rising edge
//   wr_addr  in   3   destination register index
//   wr_data  in  16   write data (normally the ALU Result)
//   flag_we  in   1   latch {C_in,V_in,Z_in,N_in} into the status register
//   C_in, V_in, Z_in, N_in  in 1 each   ALU flag outputs
//   flags    out  4   stored status {C,V,Z,N}, bit3 = C
//
// Configuration macro:
//   R0_ZERO_EN  when defined, reg[0] is hard-wired to zero: it always reads
//               0x0000 and writes to address 0 are discarded (flag updates in
//               the same cycle still apply).  When undefined, reg[0] is an
//               ordinary register.
// ---------------------------------------------------------------------------
module alu_regfile_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ra_addr,
    input  logic [2:0]  rb_addr,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        Cin,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        flag_we,
    input  logic        C_in,
    input  logic        V_in,
    input  logic        Z_in,
    input  logic        N_in,
    output logic [3:0]  flags
);

    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [3:0]  stat_q;
    logic [3:0]  stat_d;

    // Next-state for the register array.  Reads come straight from regs_q,
    // so a register being written keeps showing its old value until the edge.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
`ifdef R0_ZERO_EN
        // r0 is a constant zero; any write that targeted it is dropped here.
        regs_d[0] = 16'h0000;
`endif
    end

    // Status register next-state, independent of the register write enable.
    always_comb begin
        stat_d = stat_q;
        if (flag_we) begin
            stat_d = {C_in, V_in, Z_in, N_in};
        end
    end

    // State registers; reset clears everything immediately and wins over
    // any write presented in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: 16'h0000};
            stat_q <= 4'b0000;
        end else begin
            regs_q <= regs_d;
            stat_q <= stat_d;
        end
    end

    // Combinational read ports.
    always_comb begin
`ifdef R0_ZERO_EN
        A = (ra_addr == 3'd0) ? 16'h0000 : regs_q[ra_addr];
        B = (rb_addr == 3'd0) ? 16'h0000 : regs_q[rb_addr];
`else
        A = regs_q[ra_addr];
        B = regs_q[rb_addr];
`endif
    end

    assign Cin   = stat_q[3];
    assign flags = stat_q;

endmodule
